// File: rtl/fetch_controller_if.sv
// rtl/fetch_controller_if.sv - signal bundle between fetch controller, instruction memory and decode
//
// Purpose: groups the control inputs, the instruction-memory read port and the
//          issue outputs of the fetch controller into one bundle.
// Modports:
//   master - the fetch controller: drives mem_addr and the issue/status outputs,
//            receives start/stall/branch controls and the memory read data.
//   slave  - the surrounding system (memory, decode/execute, sequencer).
// Signals:
//   start, stall, branch_taken, branch_target   control into the controller
//   mem_addr / mem_instr                        combinational memory read port
//   instr_out, instr_valid                      issued instruction
//   busy, done, issue_count                     status

interface fetch_controller_if #(
   parameter int ADDR_W  = 8,
   parameter int INSTR_W = 9
);
   logic               start;
   logic               stall;
   logic               branch_taken;
   logic [ADDR_W-1:0]  branch_target;
   logic [INSTR_W-1:0] mem_instr;
   logic [ADDR_W-1:0]  mem_addr;
   logic [INSTR_W-1:0] instr_out;
   logic               instr_valid;
   logic               busy;
   logic               done;
   logic [15:0]        issue_count;

   modport master (
      input  start, stall, branch_taken, branch_target, mem_instr,
      output mem_addr, instr_out, instr_valid, busy, done, issue_count
   );

   modport slave (
      output start, stall, branch_taken, branch_target, mem_instr,
      input  mem_addr, instr_out, instr_valid, busy, done, issue_count
   );
endinterface

// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - PC sequencer and issue register for the 256x9 instruction memory
//
// Purpose: owns the PC, presents it to the instruction memory, captures each
//          fetched word into an issue register, applies stalls and branch
//          redirects, and stops at the halt word or at the end of memory.
// Ports:
//   clk    in   clock
//   reset  in   synchronous, active-high reset
//   bus    fetch_controller_if.master:
//     start          in   begin execution (honoured in IDLE/HALT only)
//     stall          in   hold PC and issue register this cycle
//     branch_taken   in   redirect PC to branch_target
//     branch_target  in   redirect address
//     mem_instr      in   memory word at mem_addr (same cycle)
//     mem_addr       out  PC register
//     instr_out      out  issued instruction (registered)
//     instr_valid    out  instr_out is new this cycle
//     busy           out  running
//     done           out  halted
//     issue_count    out  instructions issued since start, saturating

module fetch_controller #(
   parameter int                 ADDR_W     = 8,
   parameter int                 INSTR_W    = 9,
   parameter logic [INSTR_W-1:0] HALT_INSTR = 9'h1FF,
   parameter logic [ADDR_W-1:0]  START_ADDR = 8'h00
) (
   input  logic               clk,
   input  logic               reset,
   fetch_controller_if.master bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_HALT = 2'd2
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
   localparam logic [15:0]       COUNT_MAX = 16'hFFFF;

   state_t             state_q, state_d;
   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic               valid_q, valid_d;
   logic [15:0]        count_q, count_d;
   logic               busy_q, done_q;

   // Per-cycle decisions. Inside RUN the order is stall, then branch, then
   // halt detect, then normal issue; only the winning action takes effect.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      valid_d = 1'b0;
      count_d = count_q;

      unique case (state_q)
         S_IDLE, S_HALT: begin
            if (bus.start) begin
               state_d = S_RUN;
               pc_d    = START_ADDR;
               count_d = '0;
            end
         end

         S_RUN: begin
            if (bus.stall) begin
               // Execute keeps branch_taken asserted across the stall, so
               // the redirect is simply picked up once the stall drops.
               valid_d = 1'b0;
            end else if (bus.branch_taken) begin
               // The word currently at PC is the fall-through: squash it.
               pc_d = bus.branch_target;
            end else if (bus.mem_instr == HALT_INSTR) begin
               // PC stays on the halt word for inspection.
               state_d = S_HALT;
            end else begin
               instr_d = bus.mem_instr;
               valid_d = 1'b1;
               if (count_q != COUNT_MAX) begin
                  count_d = count_q + 16'd1;
               end
               // Issuing the last word ends the program; PC does not wrap.
               if (pc_q == LAST_ADDR) begin
                  state_d = S_HALT;
               end else begin
                  pc_d = pc_q + 1'b1;
               end
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         pc_q    <= START_ADDR;
         instr_q <= '0;
         valid_q <= 1'b0;
         count_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
         count_q <= count_d;
         // Status flags registered from the next state so they line up
         // with state_q without a decode after the flops.
         busy_q  <= (state_d == S_RUN);
         done_q  <= (state_d == S_HALT);
      end
   end

   assign bus.mem_addr    = pc_q;
   assign bus.instr_out   = instr_q;
   assign bus.instr_valid = valid_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.issue_count = count_q;

endmodule

// File: tb/tb_fetch_controller.sv
// tb/tb_fetch_controller.sv - self-checking bench for fetch_controller

module tb_fetch_controller;

   localparam logic [8:0] HALT = 9'h1FF;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   fetch_controller_if #(.ADDR_W(8), .INSTR_W(9)) bus ();

   fetch_controller dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   // Combinational instruction memory.
   logic [8:0] mem [0:255];
   assign bus.mem_instr = mem[bus.mem_addr];

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: mode 0 idle, 1 running, 2 halted.
   int         m_mode;
   int         m_pc;
   logic [8:0] m_out;
   logic       m_valid;
   int         m_cnt;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Applies one clock of the program rules to the model, reading the
   // memory word the controller is looking at this cycle.
   task automatic model_step(input logic rst, input logic st, input logic sl,
                             input logic br, input logic [7:0] tg);
      if (rst) begin
         m_mode = 0; m_pc = 0; m_out = '0; m_valid = 1'b0; m_cnt = 0;
      end else if (m_mode != 1) begin
         m_valid = 1'b0;
         if (st) begin
            m_mode = 1; m_pc = 0; m_cnt = 0;
         end
      end else if (sl) begin
         m_valid = 1'b0;
      end else if (br) begin
         m_pc = int'(tg); m_valid = 1'b0;
      end else if (mem[m_pc] == HALT) begin
         m_mode = 2; m_valid = 1'b0;
      end else begin
         m_out   = mem[m_pc];
         m_valid = 1'b1;
         if (m_cnt < 65535) m_cnt = m_cnt + 1;
         if (m_pc == 255) m_mode = 2;
         else m_pc = m_pc + 1;
      end
   endtask

   task automatic drive(input logic rst, input logic st, input logic sl,
                        input logic br, input logic [7:0] tg);
      reset             = rst;
      bus.start         = st;
      bus.stall         = sl;
      bus.branch_taken  = br;
      bus.branch_target = tg;
   endtask

   // One clock against the model; outputs sampled 1 time unit after the edge.
   task automatic step(input logic rst, input logic st, input logic sl,
                       input logic br, input logic [7:0] tg);
      drive(rst, st, sl, br, tg);
      model_step(rst, st, sl, br, tg);
      @(posedge clk);
      #1;
      chk("mem_addr", int'(bus.mem_addr), m_pc);
      chk("instr_valid", int'(bus.instr_valid), int'(m_valid));
      if (m_valid) chk("instr_out", int'(bus.instr_out), int'(m_out));
      chk("busy", int'(bus.busy), int'(m_mode == 1));
      chk("done", int'(bus.done), int'(m_mode == 2));
      chk("issue_count", int'(bus.issue_count), m_cnt);
   endtask

   task automatic load_prog1();
      for (int i = 0; i < 256; i++) mem[i] = 9'h000;
      mem[0] = 9'h10F; mem[1] = 9'h10F; mem[2] = 9'h1AB; mem[3] = HALT;
      mem[8'h40] = 9'h055; mem[8'h41] = HALT;
   endtask

   typedef struct {
      logic       rst, st, sl, br;
      logic [7:0] tg;
      logic [7:0] e_addr;
      logic       e_valid;
      logic [8:0] e_out;
      logic       e_busy, e_done;
      logic [15:0] e_cnt;
   } vec_t;

   vec_t vecs [11];

   initial begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);

      // Program 1 with a two-cycle stall after the first issue, then a
      // restart from HALT and a start that must be ignored while running.
      //          rst   st    sl    br    tg     addr   v     out     busy  done  cnt
      vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 9'h000, 1'b0, 1'b0, 16'd0};
      vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 9'h000, 1'b1, 1'b0, 16'd0};
      vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 1'b1, 9'h10F, 1'b1, 1'b0, 16'd1};
      vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h01, 1'b0, 9'h10F, 1'b1, 1'b0, 16'd1};
      vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h01, 1'b0, 9'h10F, 1'b1, 1'b0, 16'd1};
      vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h02, 1'b1, 9'h10F, 1'b1, 1'b0, 16'd2};
      vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h03, 1'b1, 9'h1AB, 1'b1, 1'b0, 16'd3};
      vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h03, 1'b0, 9'h1AB, 1'b0, 1'b1, 16'd3};
      vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h03, 1'b0, 9'h1AB, 1'b0, 1'b1, 16'd3};
      vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 9'h1AB, 1'b1, 1'b0, 16'd0};
      vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h01, 1'b1, 9'h10F, 1'b1, 1'b0, 16'd1};

      load_prog1();
      for (int i = 0; i < 11; i++) begin
         drive(vecs[i].rst, vecs[i].st, vecs[i].sl, vecs[i].br, vecs[i].tg);
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d mem_addr", i), int'(bus.mem_addr), int'(vecs[i].e_addr));
         chk($sformatf("vec%0d instr_valid", i), int'(bus.instr_valid), int'(vecs[i].e_valid));
         if (vecs[i].e_valid || vecs[i].rst)
            chk($sformatf("vec%0d instr_out", i), int'(bus.instr_out), int'(vecs[i].e_out));
         chk($sformatf("vec%0d busy", i), int'(bus.busy), int'(vecs[i].e_busy));
         chk($sformatf("vec%0d done", i), int'(bus.done), int'(vecs[i].e_done));
         chk($sformatf("vec%0d issue_count", i), int'(bus.issue_count), int'(vecs[i].e_cnt));
      end

      // Branch while PC=2: the word at 2 is squashed, mem[40] issues next.
      load_prog1();
      step(1, 0, 0, 0, 8'h00);
      step(0, 1, 0, 0, 8'h00);
      step(0, 0, 0, 0, 8'h00);
      step(0, 0, 0, 0, 8'h00);
      chk("br pc before", int'(bus.mem_addr), 2);
      step(0, 0, 0, 1, 8'h40);
      chk("br squash valid", int'(bus.instr_valid), 0);
      chk("br redirect pc", int'(bus.mem_addr), 8'h40);
      step(0, 0, 0, 0, 8'h00);
      chk("br target word", int'(bus.instr_out), 9'h055);
      chk("br target valid", int'(bus.instr_valid), 1);
      step(0, 0, 0, 0, 8'h00);
      chk("br halt done", int'(bus.done), 1);

      // Branch together with stall: PC holds, redirect when stall drops.
      step(1, 0, 0, 0, 8'h00);
      step(0, 1, 0, 0, 8'h00);
      step(0, 0, 0, 0, 8'h00);
      step(0, 0, 1, 1, 8'h40);
      chk("br+stall pc held", int'(bus.mem_addr), 1);
      step(0, 0, 0, 1, 8'h40);
      chk("br after stall pc", int'(bus.mem_addr), 8'h40);
      step(0, 0, 0, 0, 8'h00);
      chk("br after stall word", int'(bus.instr_out), 9'h055);

      // No halt word anywhere: 256 issues, PC stays at FF.
      for (int i = 0; i < 256; i++) mem[i] = 9'h001;
      step(1, 0, 0, 0, 8'h00);
      step(0, 1, 0, 0, 8'h00);
      for (int i = 0; i < 260; i++) step(0, 0, 0, 0, 8'h00);
      chk("fill issue_count", int'(bus.issue_count), 256);
      chk("fill pc", int'(bus.mem_addr), 8'hFF);
      chk("fill done", int'(bus.done), 1);

      // Branch to FF is legal and ends the program after one issue.
      step(0, 1, 0, 0, 8'h00);
      step(0, 0, 0, 1, 8'hFF);
      step(0, 0, 0, 0, 8'h00);
      step(0, 0, 0, 0, 8'h00);
      chk("br FF count", int'(bus.issue_count), 1);
      chk("br FF done", int'(bus.done), 1);

      // Reset mid-RUN at PC=5 aborts at once.
      step(1, 0, 0, 0, 8'h00);
      step(0, 1, 0, 0, 8'h00);
      for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 8'h00);
      chk("mid pc before reset", int'(bus.mem_addr), 5);
      step(1, 0, 0, 0, 8'h00);
      chk("mid reset pc", int'(bus.mem_addr), 0);
      chk("mid reset valid", int'(bus.instr_valid), 0);
      chk("mid reset count", int'(bus.issue_count), 0);
      chk("mid reset busy", int'(bus.busy), 0);

      // Randomized programs and control traffic against the model.
      for (int run = 0; run < 24; run++) begin
         int halt_pos;
         for (int i = 0; i < 256; i++) mem[i] = 9'($urandom_range(0, 511));
         halt_pos = int'($urandom_range(0, 320));
         if (halt_pos < 256) mem[halt_pos] = HALT;
         step(1, 0, 0, 0, 8'h00);
         step(0, 1, 0, 0, 8'h00);
         for (int c = 0; c < 300; c++) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 11) == 0),
                 8'($urandom_range(0, 255)));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
